// File: rtl/thco_mips_top_pkg.sv
// Shared constants for the THCO-MIPS subset core: reset levels, widths,
// opcode/funct encodings and sign-extension helpers.
// No ports; imported by thco_mips_top and thco_mips_top_regfile.
package thco_mips_top_pkg;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  localparam int DataW    = 16;
  localparam int RegAddrW = 3;
  localparam int RegNum   = 1 << RegAddrW;

  localparam logic [DataW-1:0] ZeroWord = 16'h0000;
  localparam logic [DataW-1:0] NopInst  = 16'h0800;

  // Major opcodes, instruction bits [15:11]
  typedef enum logic [4:0] {
    OP_B     = 5'b00010,
    OP_BEQZ  = 5'b00100,
    OP_BNEZ  = 5'b00101,
    OP_SLL   = 5'b00110,
    OP_ADDIU = 5'b01001,
    OP_LI    = 5'b01101,
    OP_LW    = 5'b10011,
    OP_SW    = 5'b11011,
    OP_RRR   = 5'b11100,
    OP_RR    = 5'b11101
  } opcode_e;

  // Sub-function fields
  localparam logic [1:0] F_ADDU = 2'b01;
  localparam logic [1:0] F_SUBU = 2'b11;
  localparam logic [1:0] F_SLL  = 2'b00;
  localparam logic [4:0] F_JR   = 5'b00000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01101;

  function automatic logic [DataW-1:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [DataW-1:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  function automatic logic [DataW-1:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/thco_mips_top_regfile.sv
// 8x16 register file, two combinational read ports and one write port.
// Ports: clk, rst (async active-low), raddr1/rdata1, raddr2/rdata2, we/waddr/wdata.
// All entries clear asynchronously while rst is low; R0 is an ordinary register.
module thco_mips_top_regfile
  import thco_mips_top_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] raddr1,
  output logic [DataW-1:0]    rdata1,
  input  logic [RegAddrW-1:0] raddr2,
  output logic [DataW-1:0]    rdata2,
  input  logic                we,
  input  logic [RegAddrW-1:0] waddr,
  input  logic [DataW-1:0]    wdata
);

  logic [DataW-1:0] regs [RegNum];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/thco_mips_top.sv
// Single-cycle 16-bit THCO-MIPS subset CPU: PC, instruction ROM, regfile, ALU,
// branch unit and data RAM. Ports: clk, rst (async active-low) only; state is
// observed through pc, rom/ram arrays and u_regfile.regs.
module thco_mips_top
  import thco_mips_top_pkg::*;
#(
  // Image for the instruction ROM, bound by the implementation flow; in
  // simulation the rom array is populated directly.
  parameter string ROM_FILE  = "inst_rom.data",
  parameter int    ROM_DEPTH = 256,
  parameter int    RAM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst
);

  // Depths are powers of two so wrapping is a plain truncation/mask.
  localparam int               RomAw  = $clog2(ROM_DEPTH);
  localparam int               RamAw  = $clog2(RAM_DEPTH);
  localparam logic [DataW-1:0] PcMask = DataW'(ROM_DEPTH - 1);

  logic [DataW-1:0] rom [ROM_DEPTH];
  logic [DataW-1:0] ram [RAM_DEPTH];

  logic [DataW-1:0]    pc;
  logic [DataW-1:0]    pc_inc;
  logic [DataW-1:0]    next_pc;
  logic [DataW-1:0]    inst;
  logic [4:0]          op;
  logic [RegAddrW-1:0] rx, ry, rz;
  logic [DataW-1:0]    rd_a, rd_b;
  logic [3:0]          sll_sh;
  logic [DataW-1:0]    mem_addr;
  logic [RamAw-1:0]    ram_idx;
  logic [DataW-1:0]    ram_rdata;

  logic                rf_we;
  logic [RegAddrW-1:0] rf_waddr;
  logic [DataW-1:0]    rf_wdata;
  logic                ram_we;

  assign inst   = rom[RomAw'(pc)];
  assign op     = inst[15:11];
  assign rx     = inst[10:8];
  assign ry     = inst[7:5];
  assign rz     = inst[4:2];
  assign pc_inc = pc + 16'd1;

  // A zero shift field encodes a shift by 8.
  assign sll_sh = (inst[4:2] == 3'd0) ? 4'd8 : {1'b0, inst[4:2]};

  assign mem_addr  = rd_a + sext5(inst[4:0]);
  assign ram_idx   = RamAw'(mem_addr);
  assign ram_rdata = ram[ram_idx];

  thco_mips_top_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rx),
    .rdata1 (rd_a),
    .raddr2 (ry),
    .rdata2 (rd_b),
    .we     (rf_we & (rst == RstDisable)),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  // Decode, ALU and branch resolution; anything not matched falls through
  // as a NOP (no writes, pc+1).
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rx;
    rf_wdata = ZeroWord;
    ram_we   = 1'b0;
    next_pc  = pc_inc;
    case (op)
      OP_ADDIU: begin
        rf_we    = 1'b1;
        rf_wdata = rd_a + sext8(inst[7:0]);
      end
      OP_LI: begin
        rf_we    = 1'b1;
        rf_wdata = {8'h00, inst[7:0]};
      end
      OP_RRR: begin
        rf_waddr = rz;
        if (inst[1:0] == F_ADDU) begin
          rf_we    = 1'b1;
          rf_wdata = rd_a + rd_b;
        end else if (inst[1:0] == F_SUBU) begin
          rf_we    = 1'b1;
          rf_wdata = rd_a - rd_b;
        end
      end
      OP_RR: begin
        if (inst[4:0] == F_AND) begin
          rf_we    = 1'b1;
          rf_wdata = rd_a & rd_b;
        end else if (inst[4:0] == F_OR) begin
          rf_we    = 1'b1;
          rf_wdata = rd_a | rd_b;
        end else if (inst[4:0] == F_JR && ry == 3'd0) begin
          next_pc = rd_a;
        end
      end
      OP_SLL: begin
        if (inst[1:0] == F_SLL) begin
          rf_we    = 1'b1;
          rf_wdata = rd_b << sll_sh;
        end
      end
      OP_B: begin
        next_pc = pc_inc + sext11(inst[10:0]);
      end
      OP_BEQZ: begin
        if (rd_a == ZeroWord) next_pc = pc_inc + sext8(inst[7:0]);
      end
      OP_BNEZ: begin
        if (rd_a != ZeroWord) next_pc = pc_inc + sext8(inst[7:0]);
      end
      OP_LW: begin
        rf_we    = 1'b1;
        rf_waddr = ry;
        rf_wdata = ram_rdata;
      end
      OP_SW: begin
        ram_we = (rst == RstDisable);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) pc <= ZeroWord;
    else                  pc <= next_pc & PcMask;
  end

  // Data RAM has no reset; a store is visible to a load on the next cycle.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= rd_b;
  end

endmodule

// File: tb/tb_thco_mips_top.sv
module tb_thco_mips_top;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0 = pc, 1 = register, 2 = data RAM word
    int          idx;
    logic [15:0] exp;
  } chk_t;

  chk_t sb[$];

  thco_mips_top #(
    .ROM_FILE  ("inst_rom.data"),
    .ROM_DEPTH (256),
    .RAM_DEPTH (256)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Instruction encoders
  function automatic logic [15:0] e_li(input logic [2:0] rx, input logic [7:0] imm);
    return {5'b01101, rx, imm};
  endfunction
  function automatic logic [15:0] e_addiu(input logic [2:0] rx, input logic [7:0] imm);
    return {5'b01001, rx, imm};
  endfunction
  function automatic logic [15:0] e_addu(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] rz);
    return {5'b11100, rx, ry, rz, 2'b01};
  endfunction
  function automatic logic [15:0] e_subu(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] rz);
    return {5'b11100, rx, ry, rz, 2'b11};
  endfunction
  function automatic logic [15:0] e_and(input logic [2:0] rx, input logic [2:0] ry);
    return {5'b11101, rx, ry, 5'b01100};
  endfunction
  function automatic logic [15:0] e_or(input logic [2:0] rx, input logic [2:0] ry);
    return {5'b11101, rx, ry, 5'b01101};
  endfunction
  function automatic logic [15:0] e_jr(input logic [2:0] rx);
    return {5'b11101, rx, 3'b000, 5'b00000};
  endfunction
  function automatic logic [15:0] e_sll(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] sh);
    return {5'b00110, rx, ry, sh, 2'b00};
  endfunction
  function automatic logic [15:0] e_b(input logic [10:0] off);
    return {5'b00010, off};
  endfunction
  function automatic logic [15:0] e_beqz(input logic [2:0] rx, input logic [7:0] off);
    return {5'b00100, rx, off};
  endfunction
  function automatic logic [15:0] e_bnez(input logic [2:0] rx, input logic [7:0] off);
    return {5'b00101, rx, off};
  endfunction
  function automatic logic [15:0] e_lw(input logic [2:0] rx, input logic [2:0] ry, input logic [4:0] off);
    return {5'b10011, rx, ry, off};
  endfunction
  function automatic logic [15:0] e_sw(input logic [2:0] rx, input logic [2:0] ry, input logic [4:0] off);
    return {5'b11011, rx, ry, off};
  endfunction

  function automatic logic [15:0] observe(input int kind, input int idx);
    case (kind)
      0:       return dut.pc;
      1:       return dut.u_regfile.regs[idx];
      default: return dut.ram[idx];
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int idx, input logic [15:0] exp);
    chk_t c;
    c.tag  = tag;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic drain();
    chk_t        c;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      obs = observe(c.kind, c.idx);
      total++;
      assert (obs === c.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.exp);
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.rom[i] = 16'h0800;
  endtask

  // Enter reset between edges and blank the ROM; caller loads a program
  // and then calls release_rst, which lets the next rising edge run rom[0].
  task automatic enter_rst();
    @(negedge clk);
    rst = 1'b0;
    clear_rom();
  endtask

  task automatic release_rst();
    #5 rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_arith();
    dut.rom[0] = e_li(3'd1, 8'd5);
    dut.rom[1] = e_addiu(3'd1, 8'hFF);
    dut.rom[2] = e_li(3'd2, 8'd3);
    dut.rom[3] = e_addu(3'd1, 3'd2, 3'd3);
    dut.rom[4] = e_subu(3'd1, 3'd2, 3'd4);
  endtask

  initial begin
    rst = 1'b1;
    clear_rom();
    load_arith();

    // ---- reset: low from 1 ns to 16 ns, first live edge at 30 ns ----
    #1 rst = 1'b0;
    #4;
    expect_val("rst_pc", 0, 0, 16'h0000);
    for (int r = 0; r < 8; r++) expect_val($sformatf("rst_r%0d", r), 1, r, 16'h0000);
    drain();
    #11 rst = 1'b1;

    run(1);
    expect_val("first_pc", 0, 0, 16'h0001);
    expect_val("first_r1", 1, 1, 16'h0005);
    drain();

    // ---- arithmetic ----
    run(4);
    expect_val("arith_r1", 1, 1, 16'h0004);
    expect_val("arith_r2", 1, 2, 16'h0003);
    expect_val("arith_r3", 1, 3, 16'h0007);
    expect_val("arith_r4", 1, 4, 16'h0001);
    expect_val("arith_pc", 0, 0, 16'h0005);
    drain();

    // ---- logic and shift ----
    enter_rst();
    dut.rom[0] = e_li(3'd1, 8'hF0);
    dut.rom[1] = e_li(3'd2, 8'h3C);
    dut.rom[2] = e_and(3'd1, 3'd2);
    dut.rom[3] = e_sll(3'd3, 3'd1, 3'd0);
    dut.rom[4] = e_or(3'd2, 3'd1);
    dut.rom[5] = e_sll(3'd4, 3'd2, 3'd3);
    expect_val("logic_r1_and", 1, 1, 16'h0030);
    expect_val("logic_r3_sll8", 1, 3, 16'h3000);
    expect_val("logic_r2_or", 1, 2, 16'h003C);
    expect_val("logic_r4_sll3", 1, 4, 16'h01E0);
    expect_val("logic_pc", 0, 0, 16'h0006);
    release_rst();
    run(6);
    drain();

    // ---- conditional branches ----
    enter_rst();
    dut.rom[0] = e_li(3'd1, 8'd0);
    dut.rom[1] = e_beqz(3'd1, 8'd1);
    dut.rom[2] = e_li(3'd2, 8'd1);
    dut.rom[3] = e_li(3'd3, 8'd2);
    dut.rom[4] = e_bnez(3'd1, 8'd1);
    dut.rom[5] = e_li(3'd4, 8'd4);
    dut.rom[6] = e_bnez(3'd3, 8'd1);
    dut.rom[7] = e_li(3'd5, 8'd9);
    dut.rom[8] = e_li(3'd6, 8'd6);
    expect_val("beqz_skip_r2", 1, 2, 16'h0000);
    expect_val("beqz_tgt_r3", 1, 3, 16'h0002);
    expect_val("bnez_fall_r4", 1, 4, 16'h0004);
    expect_val("bnez_skip_r5", 1, 5, 16'h0000);
    expect_val("bnez_tgt_r6", 1, 6, 16'h0006);
    expect_val("branch_pc", 0, 0, 16'h0009);
    release_rst();
    run(7);
    drain();

    // ---- JR and B with wrap at ROM depth ----
    enter_rst();
    dut.rom[0]     = e_li(3'd7, 8'h20);
    dut.rom[1]     = e_jr(3'd7);
    dut.rom[8'h20] = e_b(11'h7DE);          // 0x21 - 34 = -1 -> 0xFF
    dut.rom[8'hFF] = e_li(3'd6, 8'h77);
    release_rst();
    expect_val("jr_pc", 0, 0, 16'h0020);
    run(2);
    drain();
    expect_val("b_wrap_pc", 0, 0, 16'h00FF);
    run(1);
    drain();
    expect_val("pc_wrap_zero", 0, 0, 16'h0000);
    expect_val("wrap_r6", 1, 6, 16'h0077);
    run(1);
    drain();

    // ---- memory ----
    enter_rst();
    dut.rom[0] = e_li(3'd1, 8'h10);
    dut.rom[1] = e_li(3'd2, 8'hAB);
    dut.rom[2] = e_sw(3'd1, 3'd2, 5'd0);
    dut.rom[3] = e_lw(3'd1, 3'd5, 5'd0);
    dut.rom[4] = e_sw(3'd1, 3'd2, 5'h1F);
    dut.rom[5] = e_lw(3'd1, 3'd6, 5'h1F);
    dut.rom[6] = 16'hF800;                  // undecoded opcode 11111
    dut.rom[7] = e_li(3'd3, 8'd1);
    expect_val("sw_ram10", 2, 16'h10, 16'h00AB);
    expect_val("lw_r5", 1, 5, 16'h00AB);
    expect_val("sw_neg_ram0f", 2, 16'h0F, 16'h00AB);
    expect_val("lw_neg_r6", 1, 6, 16'h00AB);
    expect_val("undec_r1", 1, 1, 16'h0010);
    expect_val("mem_r3", 1, 3, 16'h0001);
    expect_val("mem_pc", 0, 0, 16'h0008);
    release_rst();
    run(8);
    drain();

    // ---- asynchronous reset mid-program ----
    enter_rst();
    load_arith();
    release_rst();
    repeat (4) @(posedge clk);
    #5 rst = 1'b0;
    #1;
    expect_val("async_pc", 0, 0, 16'h0000);
    expect_val("async_r1", 1, 1, 16'h0000);
    expect_val("async_r2", 1, 2, 16'h0000);
    expect_val("async_r3", 1, 3, 16'h0000);
    drain();
    #2 rst = 1'b1;
    run(5);
    expect_val("rerun_r1", 1, 1, 16'h0004);
    expect_val("rerun_r3", 1, 3, 16'h0007);
    expect_val("rerun_r4", 1, 4, 16'h0001);
    expect_val("rerun_pc", 0, 0, 16'h0005);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thco_mips_top.md
# thco_mips_top

Single-cycle 16-bit THCO-MIPS subset processor and the top of the CPU hierarchy. Contains the PC, instruction ROM, 8-entry register file, ALU, branch unit and data RAM. The only ports are clock and reset; state is observed hierarchically by the bench through the register file, PC and data RAM.

## Interface
Parameters:
- ROM_FILE, "inst_rom.data": hex file loaded into instruction ROM at elaboration.
- ROM_DEPTH, 256: instruction words; PC wraps modulo depth.
- RAM_DEPTH, 256: data words; address taken modulo depth.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (`RstEnable` = 1'b0, `RstDisable` = 1'b1).

## Operation
- Word-addressed 16-bit datapath; PC and memory addresses are 16 bits, low bits index arrays.
- ROM read is combinational: inst = rom[pc].
- One instruction completes per cycle; next PC = pc+1 unless a branch is taken.
- Instruction set (bits [15:11] opcode):
  - ADDIU 01001 rx imm8: R[rx] += sext(imm8).
  - LI 01101 rx imm8: R[rx] = zext(imm8).
  - ADDU 11100 rx ry rz 01: R[rz] = R[rx]+R[ry]; SUBU ...11: R[rz] = R[rx]-R[ry].
  - 11101 rx ry funct5: AND 01100 R[rx]&=R[ry]; OR 01101 R[rx]|=R[ry]; JR when ry=0, funct=00000: pc = R[rx].
  - SLL 00110 rx ry imm3 00: R[rx] = R[ry] << (imm3==0 ? 8 : imm3).
  - B 00010 imm11: pc = pc+1+sext(imm11).
  - BEQZ 00100 rx imm8 / BNEZ 00101 rx imm8: if R[rx]==0 / !=0, pc = pc+1+sext(imm8).
  - LW 10011 rx ry imm5: R[ry] = ram[R[rx]+sext(imm5)].
  - SW 11011 rx ry imm5: ram[R[rx]+sext(imm5)] = R[ry].
  - NOP 0x0800; any undecoded word executes as NOP (no register or memory write, pc+1).
- All arithmetic is modulo 2^16; no flags, no exceptions.
- Register file: 8×16, two combinational read ports, one write port; R0 is an ordinary register.

## Timing
- While rst = 0: pc = 0, all registers = 0, datapath writes disabled; asynchronous entry.
- Data RAM is not reset; its contents are X until written.
- First rising edge after rst rises executes rom[0].
- Register write, RAM write and PC update all on the same rising edge; results visible to the next instruction with zero stall.
- LW reads RAM combinationally; SW followed immediately by LW to the same address returns the stored value.
- Reset asserted mid-program: pc and registers clear immediately, without waiting for a clock edge; execution restarts at 0 after release.
- PC and taken-branch targets wrap at ROM_DEPTH.

## Structure
- Shared package/defines: `RstEnable`/`RstDisable`, opcode and funct constants, `ZeroWord` (16'h0000), `NopInst` (16'h0800), data width 16, register address width 3.
- Natural sub-module: `regfile` (8×16, async reset, 2R1W). ALU, decode, ROM and RAM stay inline in `thco_mips_top`.

## Test plan
- Reset: hold rst = 0 for 15 ns with a 20 ns clock -> pc = 0 and R0–R7 = 0 before the first edge; after release, pc = 1 after the first edge.
- Arithmetic: program LI R1,5; ADDIU R1,0xFF; LI R2,3; ADDU R1,R2,R3; SUBU R1,R2,R4 -> R1 = 4, R3 = 7, R4 = 1 after 5 cycles.
- Logic/shift: LI R1,0xF0; LI R2,0x3C; AND R1,R2; SLL R3,R1,0 -> R1 = 0x0030, R3 = 0x3000.
- Branch: LI R1,0; BEQZ R1,+1; LI R2,1; LI R3,2 -> R2 stays 0, R3 = 2; a BNEZ on the same zero register falls through.
- Memory: LI R1,0x10; LI R2,0xAB; SW R1,R2,0; LW R1,R5,0 -> ram[0x10] = 0x00AB, R5 = 0x00AB.
- Async reset mid-run: drop rst between edges after 4 instructions -> pc and registers read 0 within the same cycle; the program re-executes from 0 after release.
